// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator for the fetch stage.
//
// Holds the architectural PC, resolves RV32I branch conditions plus JAL/JALR,
// and drives a req/ack fetch handshake. A redirect that arrives while a fetch
// is unacknowledged is parked in `pend` so the request address stays stable;
// the stale response is then dropped (inst_valid=0).
//
// Optional feature: define PC_TRAP_EN to add `trap`/`trap_vec`, a redirect
// source with priority over branches and jumps.
//
// Ports:
//   clk, rst            core clock (rising edge), async active-high reset
//   stall               freeze sequential advance (redirects still honoured)
//   br_en, br_funct     conditional branch and its funct3
//   zero, lt, ltu       ALU compare flags for rs1 vs rs2
//   jal, jalr           unconditional jumps
//   ex_pc, imm, rs1     operands for target computation
//   if_req, if_addr     fetch request and address (address == PC register)
//   if_ack              memory accepts request, data returned same cycle
//   inst_valid          returned instruction belongs to current path
//   redirect            1-cycle flush pulse for IF/ID
//   misalign            1-cycle pulse, taken target has bit 1 set
//   trap, trap_vec      (PC_TRAP_EN only) highest-priority redirect
module pc_gen #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] RST_VEC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_en,
  input  logic [2:0]        br_funct,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic              jal,
  input  logic              jalr,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] rs1,
`ifdef PC_TRAP_EN
  input  logic              trap,
  input  logic [ADDR_W-1:0] trap_vec,
`endif
  output logic              if_req,
  output logic [ADDR_W-1:0] if_addr,
  input  logic              if_ack,
  output logic              inst_valid,
  output logic              redirect,
  output logic              misalign
);

  // state   | meaning
  // S_RESET | held in reset, no fetch request
  // S_FETCH | requesting if_addr = PC
  // S_DRAIN | old request still outstanding, redirect target waits in pend
  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LSB_CLR = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] INC4    = ADDR_W'(4);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] pend, pend_nxt;

  logic              br_tk;
  logic              tk;
  logic              trap_hit;
  logic [ADDR_W-1:0] target;
  logic              active;

  always_comb begin
    br_tk = 1'b0;
    case (br_funct)
      3'b000:  br_tk = zero;
      3'b001:  br_tk = ~zero;
      3'b100:  br_tk = lt;
      3'b101:  br_tk = ~lt;
      3'b110:  br_tk = ltu;
      3'b111:  br_tk = ~ltu;
      default: br_tk = 1'b0;
    endcase
  end

  always_comb begin
    trap_hit = 1'b0;
    tk       = (br_en & br_tk) | jal | jalr;
    if (jalr) target = (rs1 + imm) & LSB_CLR;
    else      target = ex_pc + imm;
`ifdef PC_TRAP_EN
    if (trap) begin
      trap_hit = 1'b1;
      tk       = 1'b1;
      target   = trap_vec;
    end
`endif
  end

  // Flag outputs stay quiet in reset so the reset values hold regardless of
  // whatever the execute stage presents.
  assign active   = (state != S_RESET);
  assign redirect = active & tk & (trap_hit | ~target[1]);
  assign misalign = active & tk & ~trap_hit & target[1];

  assign if_req  = active;
  assign if_addr = pc;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    pend_nxt   = pend;
    inst_valid = 1'b0;
    case (state)
      S_RESET: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          // Without an ack the address must not move under the request.
          if (if_ack) begin
            pc_nxt = target;
          end else begin
            pend_nxt  = target;
            state_nxt = S_DRAIN;
          end
        end else if (if_ack) begin
          inst_valid = 1'b1;
          if (!stall && !misalign) pc_nxt = pc + INC4;
        end
      end
      S_DRAIN: begin
        // Whatever returns here is on the abandoned path.
        if (redirect) begin
          pend_nxt = target;
          if (if_ack) begin
            pc_nxt    = target;
            state_nxt = S_FETCH;
          end
        end else if (if_ack) begin
          pc_nxt    = pend;
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
      pc    <= RST_VEC;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      pend  <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam int          AW  = 32;
  localparam logic [31:0] RSV = 32'h100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0, br_en = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic          jal = 1'b0, jalr = 1'b0, if_ack = 1'b0;
  logic [2:0]    br_funct = 3'b0;
  logic [AW-1:0] ex_pc = '0, imm = '0, rs1 = '0;
  logic          if_req, inst_valid, redirect, misalign;
  logic [AW-1:0] if_addr;
`ifdef PC_TRAP_EN
  logic          trap = 1'b0;
  logic [AW-1:0] trap_vec = '0;
`endif

  pc_gen #(.ADDR_W(AW), .RST_VEC(RSV)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_en(br_en), .br_funct(br_funct),
    .zero(zero), .lt(lt), .ltu(ltu), .jal(jal), .jalr(jalr),
    .ex_pc(ex_pc), .imm(imm), .rs1(rs1),
`ifdef PC_TRAP_EN
    .trap(trap), .trap_vec(trap_vec),
`endif
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .inst_valid(inst_valid), .redirect(redirect), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br_en;
    logic [2:0]  funct;
    logic        zero, lt, ltu, jal, jalr;
    logic [31:0] ex_pc, imm, rs1;
    logic        ack;
    logic [31:0] e_addr;
    logic        e_req, e_iv, e_redir, e_mis;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        req, iv, redir, mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic st, logic be, logic [2:0] f, logic z, logic l,
                              logic lu, logic j, logic jr, logic [31:0] ep,
                              logic [31:0] im, logic [31:0] r1, logic ak,
                              logic [31:0] ea, logic iv, logic rd, logic ms);
    vec_t v;
    v.stall = st; v.br_en = be; v.funct = f; v.zero = z; v.lt = l; v.ltu = lu;
    v.jal = j; v.jalr = jr; v.ex_pc = ep; v.imm = im; v.rs1 = r1; v.ack = ak;
    v.e_addr = ea; v.e_req = 1'b1; v.e_iv = iv; v.e_redir = rd; v.e_mis = ms;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    stall = v.stall; br_en = v.br_en; br_funct = v.funct; zero = v.zero;
    lt = v.lt; ltu = v.ltu; jal = v.jal; jalr = v.jalr; ex_pc = v.ex_pc;
    imm = v.imm; rs1 = v.rs1; if_ack = v.ack;
  endtask

  task automatic idle();
    stall = 0; br_en = 0; br_funct = 0; zero = 0; lt = 0; ltu = 0;
    jal = 0; jalr = 0; ex_pc = 0; imm = 0; rs1 = 0; if_ack = 0;
  endtask

  task automatic expect_push(input string nm, input logic [31:0] a, input logic rq,
                             input logic iv, input logic rd, input logic ms);
    exp_t e;
    e.name = nm; e.addr = a; e.req = rq; e.iv = iv; e.redir = rd; e.mis = ms;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry for DUT output");
      return;
    end
    e = sb.pop_front();
    if (if_addr !== e.addr || if_req !== e.req || inst_valid !== e.iv ||
        redirect !== e.redir || misalign !== e.mis) begin
      errors++;
      $display("FAIL %s: got addr=%h req=%b iv=%b redir=%b mis=%b, want addr=%h req=%b iv=%b redir=%b mis=%b",
               e.name, if_addr, if_req, inst_valid, redirect, misalign,
               e.addr, e.req, e.iv, e.redir, e.mis);
    end
  endtask

  initial begin
    // Cycle-by-cycle table starting right after reset, PC = 0x100.
    //            st be  f    z  l  lu j  jr ex_pc         imm           rs1           ak  exp_addr      iv rd ms
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h100,  1, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h104,  1, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h108,  1, 0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 0, 0, 0, 0, 0, 32'h200,      32'hFFFFFFF0, 32'h0,    1, 32'h10C,  0, 1, 0)); // BNE taken
    vecs.push_back(mk(0, 1, 3'd0, 0, 0, 0, 0, 0, 32'h200,      32'hFFFFFFF0, 32'h0,    1, 32'h1F0,  1, 0, 0)); // BEQ not taken
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 1, 32'h0,        32'h4,        32'h1003, 0, 32'h1F4,  0, 0, 1)); // JALR misaligned
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 1, 32'h0,        32'h4,        32'h1001, 1, 32'h1F4,  0, 1, 0)); // JALR 0x1004
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h1004, 1, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 1, 0, 32'h300,      32'h100,      32'h0,    0, 32'h1008, 0, 1, 0)); // JAL, no ack -> drain
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    0, 32'h1008, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    0, 32'h1008, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h1008, 0, 0, 0)); // stale ack
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h400,  1, 0, 0));
    vecs.push_back(mk(1, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h404,  1, 0, 0)); // stall
    vecs.push_back(mk(1, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h404,  1, 0, 0));
    vecs.push_back(mk(1, 1, 3'd7, 0, 0, 0, 0, 0, 32'h500,      32'h8,        32'h0,    1, 32'h404,  0, 1, 0)); // BGEU in stall
    vecs.push_back(mk(1, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h508,  1, 0, 0));
    vecs.push_back(mk(1, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h508,  1, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h508,  1, 0, 0));
    vecs.push_back(mk(0, 1, 3'd2, 1, 1, 1, 0, 0, 32'h0,        32'h40,       32'h0,    1, 32'h50C,  1, 0, 0)); // funct 010 never
    vecs.push_back(mk(0, 1, 3'd4, 0, 1, 0, 0, 0, 32'h600,      32'h10,       32'h0,    0, 32'h510,  0, 1, 0)); // BLT -> drain
    vecs.push_back(mk(0, 1, 3'd5, 0, 0, 0, 0, 0, 32'h700,      32'h20,       32'h0,    0, 32'h510,  0, 1, 0)); // BGE, latest wins
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h510,  0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h720,  1, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 1, 0, 32'h800,      32'h0,        32'h0,    0, 32'h724,  0, 1, 0)); // drain
    vecs.push_back(mk(0, 1, 3'd6, 0, 0, 1, 0, 0, 32'h900,      32'h4,        32'h0,    1, 32'h724,  0, 1, 0)); // BLTU + ack in drain
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h904,  1, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 1, 0, 32'hFFFFFFF0, 32'h14,       32'h0,    1, 32'h908,  0, 1, 0)); // wraps to 0x4
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,    1, 32'h4,    1, 0, 0));

    // Reset state, with a taken jump presented to show the flags stay quiet.
    idle();
    jal = 1'b1; ex_pc = 32'h40; if_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    expect_push("reset_state", RSV, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pop();
    idle();
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      expect_push($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_req,
                  vecs[i].e_iv, vecs[i].e_redir, vecs[i].e_mis);
      #1;
      check_pop();
    end

    // Reset asserted mid-DRAIN discards the pending target. PC is 0x8 here.
    @(negedge clk);
    idle(); jal = 1'b1; ex_pc = 32'hA00;
    expect_push("drain_enter", 32'h8, 1'b1, 1'b0, 1'b1, 1'b0);
    #1; check_pop();
    @(negedge clk);
    idle();
    rst = 1'b1;
    expect_push("drain_reset", RSV, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; check_pop();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if_ack = 1'b1;
    expect_push("post_reset_fetch", RSV, 1'b1, 1'b1, 1'b0, 1'b0);
    #1; check_pop();
    @(negedge clk);
    expect_push("post_reset_seq", RSV + 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
    #1; check_pop();

`ifdef PC_TRAP_EN
    // Trap beats a taken branch; a misaligned trap_vec-free branch stays quiet.
    @(negedge clk);
    idle(); if_ack = 1'b1;
    br_en = 1'b1; br_funct = 3'd0; zero = 1'b1; ex_pc = 32'h300; imm = 32'h2;
    trap = 1'b1; trap_vec = 32'h80;
    expect_push("trap_redirect", RSV + 32'h8, 1'b1, 1'b0, 1'b1, 1'b0);
    #1; check_pop();
    @(negedge clk);
    idle(); trap = 1'b0; if_ack = 1'b1;
    expect_push("trap_target", 32'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    #1; check_pop();
`endif

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the core's fetch stage. It holds the architectural PC register, resolves all six RV32I branch conditions plus JAL/JALR, and drives a req/ack handshake to instruction memory. It also absorbs redirects that arrive while a fetch is outstanding, discarding the stale response. It sits between the execute-stage ALU flags and the instruction-fetch port, and supersedes the purely combinational next-PC mux.

## Interface
- `ADDR_W`, default 32: PC and immediate width.
- `RST_VEC`, default 0: PC value loaded on reset.
- `clk` in, 1: core clock; rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `stall` in, 1: freeze sequential PC advance; redirects are still honoured.
- `br_en` in, 1: execute-stage instruction is a conditional branch.
- `br_funct` in, 3: RV32I funct3 of the branch.
- `zero`, `lt`, `ltu` in, 1 each: ALU flags for rs1 vs rs2 (equal, signed less, unsigned less).
- `jal` in, 1: execute-stage instruction is JAL.
- `jalr` in, 1: execute-stage instruction is JALR.
- `ex_pc` in, ADDR_W: PC of the execute-stage instruction.
- `imm` in, ADDR_W: sign-extended immediate.
- `rs1` in, ADDR_W: rs1 value, used by JALR.
- `if_req` out, 1: fetch request.
- `if_addr` out, ADDR_W: fetch address, equal to the PC register.
- `if_ack` in, 1: memory accepts the request and returns data in the same cycle.
- `inst_valid` out, 1: the returned instruction belongs to the current path.
- `redirect` out, 1: 1-cycle flush pulse to the IF/ID pipeline registers.
- `misalign` out, 1: 1-cycle pulse when the taken target has `target[1]` set.

## Operation
- Taken condition `tk`:
  - `br_en` with funct3 000 → `zero`; 001 → `~zero`; 100 → `lt`; 101 → `~lt`; 110 → `ltu`; 111 → `~ltu`; 010 and 011 → never taken.
  - Or `jal`, or `jalr`.
- Target:
  - Branch and JAL: `ex_pc + imm`.
  - JALR: `(rs1 + imm) & ~1`.
  - Arithmetic is modulo 2^ADDR_W; carry is dropped.
- `redirect` = `tk & ~target[1]`.
- `misalign` = `tk & target[1]`. On misalign the PC does not change.
- States:
  - RESET: entered while `rst` is high. `if_req`=0.
  - FETCH: `if_req`=1 and `if_addr`=PC.
  - DRAIN: `if_req`=1 with the old address held; a redirect target is pending.
- Transitions:
  - RESET → FETCH on the first clock edge after `rst` falls.
  - FETCH with `redirect`: PC ← target, stay in FETCH. If `if_ack` is also high, `inst_valid`=0.
  - FETCH, no redirect, `if_ack`, `~stall`: PC ← PC + 4, `inst_valid`=1.
  - FETCH, no redirect, `if_ack`, `stall`: PC held, `inst_valid`=1. The same address is re-presented next cycle, so the consumer must drop duplicates while stalled.
  - FETCH, no redirect, no `if_ack`: hold. `if_addr` stays stable; `if_req` is never withdrawn while unacked.
  - This policy keeps the req/ack address stable: redirect without `if_ack` while `if_req` is high → latch target into `pend`, go to DRAIN, PC unchanged.
  - DRAIN with `if_ack`: `inst_valid`=0, PC ← `pend`, go to FETCH.
  - DRAIN with a new `redirect`: `pend` ← new target (latest wins). If `if_ack` is high in the same cycle, PC ← new target directly.
- Priority: redirect > stall > sequential advance.

## Timing
- Reset values: PC=`RST_VEC`, `pend`=0, state RESET, `if_req`=0, `inst_valid`=0, `redirect`=0, `misalign`=0.
- `redirect`, `misalign` and `inst_valid` are combinational in the decision cycle.
- PC update is registered, so the new address appears on `if_addr` one cycle after the decision.
- Redirect to first new-path request: 1 cycle in FETCH; ack cycle + 1 in DRAIN.
- Sequential throughput: one instruction per cycle with `if_ack` held high.
- `rst` asserted mid-DRAIN aborts immediately: `pend` is discarded and PC=`RST_VEC`.

## Configuration
- Macro `PC_TRAP_EN`.
- Defined: adds inputs `trap` (1) and `trap_vec` (ADDR_W).
  - `trap` has priority above every redirect: target `trap_vec`, asserts `redirect`, suppresses `misalign`.
  - DRAIN handling is identical to a normal redirect.
- Undefined: the ports are absent and only branch/jump redirects exist.

## Test plan
- Reset then free run: `RST_VEC`=0x100, `if_ack`=1 → `if_addr` 0x100, 0x104, 0x108 on consecutive cycles, with `inst_valid`=1.
- BNE taken: `br_en`=1, funct3=001, `zero`=0, `ex_pc`=0x200, `imm`=0xFFFFFFF0 → `redirect` pulse, next `if_addr`=0x1F0. BEQ under the same flags → no redirect.
- JALR: `rs1`=0x1003, `imm`=4 → target 0x1006 → `misalign`=1, `redirect`=0, PC unchanged. With `rs1`=0x1001 → target 0x1004, redirect.
- Redirect during outstanding fetch: `if_ack`=0, JAL to 0x400 → `if_addr` held at the old address. Ack 3 cycles later → `inst_valid`=0, next `if_addr`=0x400.
- Stall: `stall`=1 for 4 cycles with `if_ack`=1 → `if_addr` constant. A BGEU taken during the stall (`ltu`=0) still redirects.
- With `PC_TRAP_EN` defined: `trap`=1, `trap_vec`=0x80 in the same cycle as a taken branch → next `if_addr`=0x80.
